mm_row_collector: RTL and testbench
===================================

Name: mm_row_collector

Overview:
- Downstream of the 16-lane fp32 dot-product pipeline. Consumes one scalar result per valid cycle and packs NUM consecutive results into one output-matrix row.
- Buffers rows in a small FIFO and presents them to the output-buffer writer over a valid/ready handshake.
- The dot-product pipeline cannot stall, so the block exports almost_full for the issue scheduler to throttle, and flags any loss.

Parameters:
- NUM, 16, results per packed row (lanes); power of two, ≥2.
- DW, 32, result width (fp32).
- DEPTH, 4, FIFO depth in rows; power of two, ≥2.
- AF_MARGIN, 2, almost_full asserts when occupancy ≥ DEPTH-AF_MARGIN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a tile. Ignored unless IDLE.
- tile_rows  input  16  rows in the tile; sampled on start.
- result_data  input  DW  scalar from the dot-product stage.
- result_valid  input  1  result_data valid; no backpressure possible.
- out_data  output  NUM*DW  packed row; lane k at bits [(k+1)*DW-1:k*DW].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_last  output  1  head is the tile's final row.
- almost_full  output  1  throttle request to scheduler.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at tile completion.
- overflow  output  1  sticky: completed row dropped, FIFO full.
- stray  output  1  sticky: result_valid seen while not COLLECT.

Behaviour:
- Reset (async, any state): state=IDLE; lane, row, FIFO pointers and occupancy=0; out_valid, out_last, almost_full, busy, done, overflow, stray=0; out_data=0. A partial row is discarded.
- States:
  - IDLE: start with tile_rows>0 → COLLECT, clears lane/row counters, overflow, stray. start with tile_rows=0 → done pulses next cycle, stays IDLE.
  - COLLECT: each result_valid writes result_data into lane register [lane], lane++. At lane=NUM-1 the completed row (including the current result) is pushed at that edge, lane wraps to 0, row++. The push where row=tile_rows-1 tags the entry last and moves → DRAIN.
  - DRAIN: results set stray and are dropped. When occupancy=0 → IDLE with done pulsed on that transition cycle.
- Lane order: first result of a row → lane 0.
- FIFO:
  - Entry is NUM*DW data + last bit.
  - out_valid = occupancy>0; out_data and out_last reflect the head combinationally from registered storage.
  - Pop on out_valid&&out_ready.
  - Latency: row-completing result at edge N → out_valid high after edge N if FIFO was empty.
- Push while full:
  - With simultaneous pop: accepted, occupancy unchanged.
  - Without pop: row dropped, overflow set, row counter still advances so the tile terminates.
  - A dropped last row: DRAIN still entered; no out_last is ever presented.
- almost_full registered from next occupancy; no combinational path from result_valid.
- Arithmetic: no datapath arithmetic except the optional feature; counters are 16-bit. start while busy is ignored.

Optional Feature:
- Macro MM_ROW_COLLECTOR_RELU_EN.
- Defined: each result passes through ReLU before lane write. Sign bit set (negatives, -0.0, negative NaN) → 32'h00000000; else unchanged. Zero added latency, purely combinational on the write path.
- Undefined: results stored bit-exact.

Test Plan:
- tile_rows=2, 32 results 1.0..32.0 (0x3F800000, 0x40000000, ...), out_ready=1 → row0 lane0=0x3F800000, lane15=0x41800000; row1 out_last=1; done one cycle after row1 pops; overflow=stray=0.
- DEPTH=4, out_ready=0, tile_rows=6, 96 results → almost_full after row2; rows 4,5 dropped, overflow=1; then out_ready=1 → exactly 4 rows popped, none out_last, done after the last pop.
- FIFO full, row completes in the same cycle as a pop → no overflow, occupancy stays 4, new row appears last in order.
- start with tile_rows=0 → done high exactly one cycle later, busy never asserts.
- rst asserted after 7 results of row0 → all outputs 0 immediately; new start plus 16 results yields a row containing only the new values.
- RELU_EN defined: inputs 0xBF800000, 0x80000000, 0x40400000 → lanes 0x00000000, 0x00000000, 0x40400000. Undefined → bit-exact passthrough.

Source files
------------

// File: rtl/mm_row_collector.sv
// mm_row_collector: packs NUM consecutive dot-product results into rows and queues them.
// Define MM_ROW_COLLECTOR_RELU_EN to clamp sign-bit-set results to zero on the lane write.
module mm_row_collector #(
   parameter int NUM       = 16,
   parameter int DW        = 32,
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       tile_rows,
   input  logic [DW-1:0]     result_data,
   input  logic              result_valid,
   output logic [NUM*DW-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              almost_full,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              stray
);

   localparam int LW = $clog2(NUM);
   localparam int PW = $clog2(DEPTH);
   localparam int RW = NUM * DW;

   localparam logic [LW-1:0] LANE_MAX = LW'(NUM - 1);
   localparam logic [PW:0]   OCC_FULL = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   AF_TH    = (PW + 1)'(DEPTH - AF_MARGIN);
   localparam logic [PW:0]   OCC_ONE  = (PW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DRAIN
   } state_t;

   state_t          state;
   logic [LW-1:0]   lane;
   logic [15:0]     row;
   logic [15:0]     tile_q;
   logic [DW-1:0]   lanes [0:NUM-2];
   logic [RW-1:0]   mem [0:DEPTH-1];
   logic            mem_last [0:DEPTH-1];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     occ;
   logic [PW:0]     occ_next;

   logic [DW-1:0]   wr_val;
   logic [RW-1:0]   row_data;
   logic            push_req;
   logic            pop;
   logic            push;
   logic            drop;
   logic            last_row;

`ifdef MM_ROW_COLLECTOR_RELU_EN
   assign wr_val = result_data[DW-1] ? '0 : result_data;
`else
   assign wr_val = result_data;
`endif

   assign push_req = (state == S_COLLECT) && result_valid && (lane == LANE_MAX);
   assign pop      = (occ != '0) && out_ready;
   // A full FIFO still takes a row when the head leaves on the same edge.
   assign push     = push_req && ((occ != OCC_FULL) || pop);
   assign drop     = push_req && (occ == OCC_FULL) && !pop;
   assign last_row = (row == tile_q - 16'd1);

   always_comb begin
      occ_next = occ;
      unique case ({push, pop})
         2'b10:   occ_next = occ + OCC_ONE;
         2'b01:   occ_next = occ - OCC_ONE;
         default: occ_next = occ;
      endcase
   end

   // The final lane comes straight from the input so the row pushes on its edge.
   always_comb begin
      row_data = '0;
      for (int k = 0; k < NUM - 1; k++) begin
         row_data[k*DW +: DW] = lanes[k];
      end
      row_data[RW-1 -: DW] = wr_val;
   end

   assign out_valid = (occ != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign out_last  = out_valid & mem_last[rd_ptr];

   always_ff @(posedge clk) begin
      if ((state == S_COLLECT) && result_valid && (lane != LANE_MAX)) begin
         lanes[lane] <= wr_val;
      end
      if (push) begin
         mem[wr_ptr]      <= row_data;
         mem_last[wr_ptr] <= last_row;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         lane        <= '0;
         row         <= '0;
         tile_q      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         almost_full <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         stray       <= 1'b0;
      end else begin
         done        <= 1'b0;
         occ         <= occ_next;
         almost_full <= (occ_next >= AF_TH);
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (result_valid && (state != S_COLLECT)) begin
            stray <= 1'b1;
         end
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (tile_rows != 16'd0) begin
                     state    <= S_COLLECT;
                     busy     <= 1'b1;
                     lane     <= '0;
                     row      <= '0;
                     tile_q   <= tile_rows;
                     overflow <= 1'b0;
                     stray    <= 1'b0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (result_valid) begin
                  lane <= lane + LW'(1);
                  if (lane == LANE_MAX) begin
                     row <= row + 16'd1;
                     if (last_row) begin
                        state <= S_DRAIN;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (occ == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_row_collector.sv
// tb_mm_row_collector: directed + random bench for mm_row_collector.
// A queue-based model of rows and the FIFO predicts every output each cycle.
module tb_mm_row_collector;

   localparam int NUM       = 16;
   localparam int DW        = 32;
   localparam int DEPTH     = 4;
   localparam int AF_MARGIN = 2;
   localparam int RW        = NUM * DW;

   localparam int PH_IDLE    = 0;
   localparam int PH_COLLECT = 1;
   localparam int PH_DRAIN   = 2;

   logic          clk;
   logic          rst;
   logic          start;
   logic [15:0]   tile_rows;
   logic [DW-1:0] result_data;
   logic          result_valid;
   logic [RW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          almost_full;
   logic          busy;
   logic          done;
   logic          overflow;
   logic          stray;

   mm_row_collector #(
      .NUM(NUM), .DW(DW), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .tile_rows(tile_rows),
      .result_data(result_data), .result_valid(result_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .almost_full(almost_full), .busy(busy),
      .done(done), .overflow(overflow), .stray(stray)
   );

   typedef struct {
      logic [RW-1:0] data;
      logic          last;
   } row_t;

   row_t          fq[$];
   logic [DW-1:0] cur[$];
   int            ph;
   int            rows_seen;
   int            tile_e;
   logic          done_e;
   logic          ovf_e;
   logic          stray_e;
   int            dut_pops;
   int            dut_lasts;
   int            n_assert;
   int            n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] relu(logic [DW-1:0] v);
`ifdef MM_ROW_COLLECTOR_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [31:0] fp_of(int i);
      int e = 0;
      while ((i >> (e + 1)) != 0) e++;
      return {1'b0, 8'(127 + e), 23'((i - (1 << e)) << (23 - e))};
   endfunction

   task automatic chk1(string tag, logic obs, logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkw(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      cur.delete();
      ph = PH_IDLE;
      rows_seen = 0;
      tile_e = 0;
      done_e = 1'b0;
      ovf_e = 1'b0;
      stray_e = 1'b0;
   endtask

   task automatic check_outputs();
      chk1("out_valid", out_valid, fq.size() != 0);
      if (fq.size() != 0) begin
         chkw("out_data", out_data, fq[0].data);
         chk1("out_last", out_last, fq[0].last);
      end
      chk1("busy", busy, ph != PH_IDLE);
      chk1("done", done, done_e);
      chk1("overflow", overflow, ovf_e);
      chk1("stray", stray, stray_e);
      chk1("almost_full", almost_full, fq.size() >= DEPTH - AF_MARGIN);
   endtask

   // Predict one clock edge from the current inputs, then check after it.
   task automatic tick();
      int   sz0 = fq.size();
      logic pop_now = (sz0 != 0) && out_ready;
      row_t r;
      if (out_valid && out_ready) begin
         dut_pops++;
         if (out_last) dut_lasts++;
      end
      done_e = 1'b0;
      if (result_valid && ph != PH_COLLECT) stray_e = 1'b1;
      case (ph)
         PH_IDLE: begin
            if (start) begin
               if (tile_rows != 16'd0) begin
                  ph = PH_COLLECT;
                  cur.delete();
                  rows_seen = 0;
                  tile_e = int'(tile_rows);
                  ovf_e = 1'b0;
                  stray_e = 1'b0;
               end else begin
                  done_e = 1'b1;
               end
            end
         end
         PH_COLLECT: begin
            if (result_valid) begin
               cur.push_back(relu(result_data));
               if (cur.size() == NUM) begin
                  for (int k = 0; k < NUM; k++) r.data[k*DW +: DW] = cur[k];
                  r.last = (rows_seen == tile_e - 1);
                  rows_seen++;
                  cur.delete();
                  if (sz0 == DEPTH && !pop_now) ovf_e = 1'b1;
                  else fq.push_back(r);
                  if (r.last) ph = PH_DRAIN;
               end
            end
         end
         default: begin
            if (sz0 == 0) begin
               ph = PH_IDLE;
               done_e = 1'b1;
            end
         end
      endcase
      if (pop_now) void'(fq.pop_front());
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive(logic s, logic [15:0] tr, logic rv, logic [DW-1:0] rd);
      start = s;
      tile_rows = tr;
      result_valid = rv;
      result_data = rd;
      tick();
   endtask

   task automatic wait_idle(int bound);
      int n = 0;
      while (ph != PH_IDLE && n < bound) begin
         drive(1'b0, 16'd0, 1'b0, '0);
         n++;
      end
      if (ph != PH_IDLE) chk1("drain_timeout", busy, 1'b0);
      drive(1'b0, 16'd0, 1'b0, '0);
   endtask

   initial begin
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic [31:0] exp2;
      n_assert = 0;
      n_fail = 0;
      dut_pops = 0;
      dut_lasts = 0;
      rst = 1'b1;
      start = 1'b0;
      tile_rows = '0;
      result_valid = 1'b0;
      result_data = '0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      chkw("reset_out_data", out_data, '0);
      rst = 1'b0;
      drive(1'b0, 16'd0, 1'b0, '0);

      // Two-row tile of 1.0 .. 32.0 with the consumer always ready.
      out_ready = 1'b1;
      drive(1'b1, 16'd2, 1'b0, '0);
      for (int i = 1; i <= 32; i++) begin
         drive(1'b0, 16'd0, 1'b1, fp_of(i));
         if (i == 16) begin
            chk32("t1_lane0", out_data[31:0], 32'h3F800000);
            chk32("t1_lane15", out_data[RW-1 -: 32], 32'h41800000);
         end
      end
      wait_idle(20);
      chk1("t1_overflow", overflow, 1'b0);
      chk1("t1_stray", stray, 1'b0);

      // Six rows into a four-deep FIFO with no consumer: rows 4 and 5 drop.
      out_ready = 1'b0;
      drive(1'b1, 16'd6, 1'b0, '0);
      for (int i = 0; i < 96; i++) begin
         drive(1'b0, 16'd0, 1'b1, $urandom);
         if (i == 47) chk1("t2_af_row2", almost_full, 1'b1);
      end
      chk1("t2_overflow", overflow, 1'b1);
      dut_pops = 0;
      dut_lasts = 0;
      out_ready = 1'b1;
      wait_idle(20);
      chk32("t2_pops", dut_pops, 32'd4);
      chk32("t2_lasts", dut_lasts, 32'd0);

      // Full FIFO while the final row lands on the same edge as a pop.
      out_ready = 1'b0;
      drive(1'b1, 16'd5, 1'b0, '0);
      for (int i = 0; i < 79; i++) drive(1'b0, 16'd0, 1'b1, $urandom);
      dut_pops = 0;
      dut_lasts = 0;
      out_ready = 1'b1;
      drive(1'b0, 16'd0, 1'b1, $urandom);
      out_ready = 1'b0;
      chk1("t3_no_overflow", overflow, 1'b0);
      chk1("t3_still_full", almost_full, 1'b1);
      drive(1'b0, 16'd0, 1'b1, $urandom);
      out_ready = 1'b1;
      wait_idle(20);
      chk32("t3_pops", dut_pops, 32'd5);
      chk32("t3_lasts", dut_lasts, 32'd1);

      // Zero-row tile.
      drive(1'b1, 16'd0, 1'b0, '0);
      chk1("t4_done", done, 1'b1);
      chk1("t4_busy", busy, 1'b0);
      drive(1'b0, 16'd0, 1'b0, '0);
      chk1("t4_done_fall", done, 1'b0);

      // Asynchronous reset in the middle of a row.
      out_ready = 1'b0;
      drive(1'b1, 16'd1, 1'b0, '0);
      for (int i = 0; i < 7; i++) drive(1'b0, 16'd0, 1'b1, $urandom);
      result_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chkw("t5_rst_data", out_data, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs();

      // Fresh row, leading lanes exercise the sign-bit handling.
      drive(1'b1, 16'd1, 1'b0, '0);
      drive(1'b0, 16'd0, 1'b1, 32'hBF800000);
      drive(1'b0, 16'd0, 1'b1, 32'h80000000);
      drive(1'b0, 16'd0, 1'b1, 32'h40400000);
      for (int i = 3; i < NUM; i++) drive(1'b0, 16'd0, 1'b1, $urandom);
`ifdef MM_ROW_COLLECTOR_RELU_EN
      exp0 = 32'h00000000;
      exp1 = 32'h00000000;
`else
      exp0 = 32'hBF800000;
      exp1 = 32'h80000000;
`endif
      exp2 = 32'h40400000;
      chk32("t6_lane0", out_data[31:0], exp0);
      chk32("t6_lane1", out_data[63:32], exp1);
      chk32("t6_lane2", out_data[95:64], exp2);
      chk1("t6_last", out_last, 1'b1);
      out_ready = 1'b1;
      wait_idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
